insn_fetch_bridge: RTL

Instruction-fetch bridge between the core's fetch port and the instruction memory. Accepts one fetch request per cycle from the core and issues it to memory through a valid/ready request channel. Tracks up to DEPTH in-flight requests in an address FIFO and returns in-order responses to the core with the matching fetched address. Supports a flush that silently discards every response still in flight.

---
 rtl/insn_fetch_bridge.sv | 138 +++++++++++++
 1 files changed

// File: rtl/insn_fetch_bridge.sv
`default_nettype none
// ============================================================================
// Module   : insn_fetch_bridge
// Purpose  : Core fetch port to instruction memory bridge with an in-order
//            address FIFO for in-flight reads and flush-discard support.
// Revision : 1.0 - initial release
// ============================================================================
module insn_fetch_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int INSN_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  insn_fetch_en,
    input  logic [ADDR_WIDTH-3:0] insn_fetch_addr,
    output logic                  insn_fetch_ready,
    output logic                  insn_fetch_valid,
    output logic [INSN_WIDTH-1:0] insn_fetch_data,
    output logic [ADDR_WIDTH-3:0] insn_fetched_addr,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-3:0] mem_req_addr,
    input  logic                  mem_rsp_valid,
    input  logic [INSN_WIDTH-1:0] mem_rsp_data,
    output logic                  err_unexpected_rsp
);
    localparam int               c_IDX_W   = $clog2(DEPTH);
    localparam logic [c_IDX_W:0] c_PTR_ONE = {{c_IDX_W{1'b0}}, 1'b1};

    logic                  r_slot_valid;
    logic [ADDR_WIDTH-3:0] r_slot_addr;
    logic [c_IDX_W:0]      r_wr_ptr;
    logic [c_IDX_W:0]      r_rd_ptr;
    logic [ADDR_WIDTH-3:0] r_fifo_addr [DEPTH];
    logic [DEPTH-1:0]      r_fifo_stale;
    logic                  r_out_valid;
    logic [INSN_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-3:0] r_out_addr;
    logic                  r_err;

    logic [c_IDX_W-1:0]    w_wr_idx;
    logic [c_IDX_W-1:0]    w_rd_idx;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_hs;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_fwd;
    logic [DEPTH-1:0]      w_stale_nxt;

    assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
    assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (w_wr_idx == w_rd_idx) && (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]);

    // Issue gate looks only at current occupancy; a same-cycle pop does not free a slot.
    assign mem_req_valid    = r_slot_valid && !w_full;
    assign mem_req_addr     = r_slot_addr;
    assign w_hs             = mem_req_valid && mem_req_ready;
    assign insn_fetch_ready = !flush && (!r_slot_valid || w_hs);
    assign w_accept         = insn_fetch_en && insn_fetch_ready;

    assign w_pop = mem_rsp_valid && !w_empty;
    assign w_fwd = w_pop && !r_fifo_stale[w_rd_idx] && !flush;

    // A flush poisons every entry, including the one being pushed right now.
    always_comb begin
        w_stale_nxt = r_fifo_stale;
        if (flush) begin
            w_stale_nxt = '1;
        end else if (w_hs) begin
            w_stale_nxt[w_wr_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_valid <= 1'b0;
            r_slot_addr  <= '0;
        end else if (flush) begin
            r_slot_valid <= 1'b0;
        end else if (w_accept) begin
            r_slot_valid <= 1'b1;
            r_slot_addr  <= insn_fetch_addr;
        end else if (w_hs) begin
            r_slot_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_stale <= '0;
        end else begin
            r_fifo_stale <= w_stale_nxt;
            if (w_hs) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_fifo_addr[w_wr_idx] <= r_slot_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= w_fwd;
            if (w_fwd) begin
                r_out_data <= mem_rsp_data;
                r_out_addr <= r_fifo_addr[w_rd_idx];
            end
            if (mem_rsp_valid && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign insn_fetch_valid   = r_out_valid;
    assign insn_fetch_data    = r_out_data;
    assign insn_fetched_addr  = r_out_addr;
    assign err_unexpected_rsp = r_err;

endmodule
`default_nettype wire
